// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_t : FSM state encoding
//   fetch_entry_t : one buffered fetch (instruction word + its pc), 64 bits
//   RESET_PC_DEFAULT, INST_NOP, PC_STEP, FIFO_DEPTH : shared constants
//   word_align()  : clears the byte-offset bits of an address
package inst_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [1:0]  FIFO_DEPTH       = 2'd2;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory and the CPU.
//   imem_*      : request/grant/response channel to instruction memory
//   inst*       : instruction handed to the CPU, cpu_ready consumes it
//   redirect*   : branch/jump redirect from the CPU
// master = fetch controller view, slave = memory/CPU side view.
interface inst_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        cpu_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid,
      input  imem_gnt, imem_rvalid, imem_rdata, cpu_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid,
      output imem_gnt, imem_rvalid, imem_rdata, cpu_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// fetch_fifo: 2-entry in-order buffer of fetched {word, pc} entries.
//   clk, rst_n : clock, async active-low reset
//   push, din  : append an entry at the tail
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries (wins over push/pop)
//   head       : head entry, straight from a register
//   full, empty, count : occupancy
module fetch_fifo
   import inst_fetch_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   fetch_entry_t ent0;
   fetch_entry_t ent1;
   logic [1:0]   cnt;
   logic         do_pop;

   assign do_pop = pop & (cnt != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= 2'd0;
      end else if (flush) begin
         cnt       <= 2'd0;
         // a flushed head reads as a NOP rather than a stale instruction
         ent0.word <= INST_NOP;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= din;
               else             ent1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; new word lands at head when it was the only one
               if (cnt == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = ent0;
   assign count = cnt;
   assign empty = (cnt == 2'd0);
   assign full  = (cnt == FIFO_DEPTH);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetches instruction words from memory into a 2-entry
// buffer and presents them in order to the CPU, with redirect/flush.
//   cpu_clk : clock
//   cpu_rst : async active-low reset
//   bus     : memory request/response, CPU instruction and redirect signals
//
// state | meaning
// IDLE  | no request outstanding; move to REQ once buffer credit exists
// REQ   | imem_req high with imem_addr = fetch_pc, waiting for grant
// WAIT  | one request granted, response goes into the buffer tail
// DROP  | one request granted but redirected away; response is discarded
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   inst_fetch_ctrl_if.master  bus
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [31:0]  fetch_pc;

   fetch_entry_t fifo_din;
   fetch_entry_t fifo_head;
   logic         fifo_full;
   logic         fifo_empty;
   logic [1:0]   fifo_count;
   logic         push;
   logic         pop;
   logic         outstanding;
   logic         credit;
   logic         granted;

   assign granted     = (state == ST_REQ) & bus.imem_gnt;
   assign outstanding = (state == ST_WAIT) | (state == ST_DROP);
   assign credit      = ({1'b0, fifo_count} + {2'b00, outstanding}) < {1'b0, FIFO_DEPTH};

   assign pop  = ~fifo_empty & bus.cpu_ready & ~bus.redirect;
   assign push = (state == ST_WAIT) & bus.imem_rvalid & ~bus.redirect & (~fifo_full | pop);

   // fetch_pc already advanced at grant and cannot change in WAIT without
   // leaving for DROP, so the outstanding address is one step behind it
   assign fifo_din = '{word: bus.imem_rdata, pc: fetch_pc - PC_STEP};

   fetch_fifo u_fifo (
      .clk   (cpu_clk),
      .rst_n (cpu_rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .din   (fifo_din),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         fetch_pc <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc <= word_align(bus.redirect_pc);
      end else if (granted) begin
         fetch_pc <= fetch_pc + PC_STEP;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus.redirect || credit) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (bus.imem_gnt) state_nxt = bus.redirect ? ST_DROP : ST_WAIT;
         end
         ST_WAIT: begin
            // a response arriving with the redirect is the one being killed,
            // so nothing is left to drop
            if (bus.imem_rvalid)      state_nxt = ST_IDLE;
            else if (bus.redirect)    state_nxt = ST_DROP;
         end
         ST_DROP: begin
            // a redirect only retargets fetch_pc; the awaited response still ends DROP
            if (bus.imem_rvalid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.imem_req   = (state == ST_REQ);
      bus.imem_addr  = fetch_pc;
      bus.inst       = fifo_head.word;
      bus.inst_pc    = fifo_head.pc;
      bus.inst_valid = ~fifo_empty;
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
   logic clk;
   logic rst;
   logic rst2;

   inst_fetch_ctrl_if bus ();
   inst_fetch_ctrl_if bus2 ();

   inst_fetch_ctrl u_dut (
      .cpu_clk (clk),
      .cpu_rst (rst),
      .bus     (bus)
   );

   inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
      .cpu_clk (clk),
      .cpu_rst (rst2),
      .bus     (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        chk_head;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic rdr, input logic [31:0] rpc,
                               input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_inst, input logic [31:0] e_pc, input logic chk_head);
      vec_t v;
      v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rdr; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_inst = e_inst; v.e_pc = e_pc; v.chk_head = chk_head;
      return v;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdr, input logic [31:0] rpc);
      bus.imem_gnt    = g;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      bus.cpu_ready   = rdy;
      bus.redirect    = rdr;
      bus.redirect_pc = rpc;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // leaves the caller at the negedge of the first cycle after reset release
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // random-phase state
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic [31:0] exp_pc;
   logic        prev_redir;
   int          n_consumed;
   logic        had_pend;
   logic        r_g, r_rv, r_rdy, r_rdr;
   logic [31:0] r_rd, r_rpc;

   // high RESET_PC instance
   logic [31:0] hi_addr [3];
   logic [31:0] hi_exp  [3];
   int          n_hi;
   logic        hi_seen;
   logic [31:0] hi_first_pc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b0;
      rst2 = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      bus2.imem_gnt    = 1'b1;
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata  = 32'h0000_0013;
      bus2.cpu_ready   = 1'b1;
      bus2.redirect    = 1'b0;
      bus2.redirect_pc = 32'h0;

      // ---- RESET_PC near the top of the address space: fetch wraps ----
      hi_exp[0] = 32'hFFFF_FFF8;
      hi_exp[1] = 32'hFFFF_FFFC;
      hi_exp[2] = 32'h0000_0000;
      n_hi = 0;
      hi_seen = 1'b0;
      hi_first_pc = 32'h0;
      repeat (3) @(negedge clk);
      chk("hi_reset_addr", bus2.imem_addr, 32'hFFFF_FFF8);
      rst2 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (bus2.imem_req && n_hi < 3) begin
            hi_addr[n_hi] = bus2.imem_addr;
            n_hi++;
         end
         if (bus2.inst_valid && !hi_seen) begin
            hi_first_pc = bus2.inst_pc;
            hi_seen = 1'b1;
         end
         step();
      end
      chk("hi_req_count", n_hi, 3);
      for (int k = 0; k < 3; k++) chk($sformatf("hi_addr%0d", k), hi_addr[k], hi_exp[k]);
      chk("hi_first_pc", hi_first_pc, 32'hFFFF_FFF8);

      // ---- table-driven: stream, backpressure, un-granted redirect ----
      vec[0]  = mk(0,0,32'h0,        0,0,32'h0,   0,32'h0,  0,32'h0,        32'h0,  1);
      vec[1]  = mk(1,0,32'h0,        0,0,32'h0,   1,32'h0,  0,32'h0,        32'h0,  0);
      vec[2]  = mk(0,1,32'h00100093, 0,0,32'h0,   0,32'h4,  0,32'h0,        32'h0,  0);
      vec[3]  = mk(0,0,32'h0,        0,0,32'h0,   0,32'h4,  1,32'h00100093, 32'h0,  1);
      vec[4]  = mk(1,0,32'h0,        0,0,32'h0,   1,32'h4,  1,32'h00100093, 32'h0,  1);
      vec[5]  = mk(0,1,32'h00200113, 0,0,32'h0,   0,32'h8,  1,32'h00100093, 32'h0,  1);
      vec[6]  = mk(0,0,32'h0,        0,0,32'h0,   0,32'h8,  1,32'h00100093, 32'h0,  1);
      vec[7]  = mk(0,0,32'h0,        1,0,32'h0,   0,32'h8,  1,32'h00100093, 32'h0,  1);
      vec[8]  = mk(0,0,32'h0,        0,0,32'h0,   0,32'h8,  1,32'h00200113, 32'h4,  1);
      vec[9]  = mk(1,0,32'h0,        1,0,32'h0,   1,32'h8,  1,32'h00200113, 32'h4,  1);
      vec[10] = mk(0,1,32'h00300193, 0,0,32'h0,   0,32'hC,  0,32'h0,        32'h0,  0);
      vec[11] = mk(0,0,32'h0,        1,0,32'h0,   0,32'hC,  1,32'h00300193, 32'h8,  1);
      vec[12] = mk(0,0,32'h0,        0,1,32'h203, 1,32'hC,  0,32'h0,        32'h0,  0);
      vec[13] = mk(1,0,32'h0,        0,0,32'h0,   1,32'h200,0,32'h0,        32'h0,  0);
      vec[14] = mk(0,1,32'h40000233, 0,0,32'h0,   0,32'h204,0,32'h0,        32'h0,  0);
      vec[15] = mk(0,0,32'h0,        0,0,32'h0,   0,32'h204,1,32'h40000233, 32'h200,1);

      do_reset();
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("vec%0d_req", i),   bus.imem_req,   vec[i].e_req);
         chk($sformatf("vec%0d_addr", i),  bus.imem_addr,  vec[i].e_addr);
         chk($sformatf("vec%0d_valid", i), bus.inst_valid, vec[i].e_valid);
         if (vec[i].chk_head) begin
            chk($sformatf("vec%0d_inst", i), bus.inst,    vec[i].e_inst);
            chk($sformatf("vec%0d_pc", i),   bus.inst_pc, vec[i].e_pc);
         end
         drive(vec[i].gnt, vec[i].rvalid, vec[i].rdata, vec[i].ready, vec[i].redir, vec[i].rpc);
         step();
      end
      drive(0, 0, 0, 0, 0, 0);

      // ---- redirect during WAIT, response 3 cycles after grant ----
      do_reset();
      step();
      chk("r37_req", bus.imem_req, 1);
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h0000_0102); step();
      chk("r37_flush_valid", bus.inst_valid, 0);
      chk("r37_no_req", bus.imem_req, 0);
      chk("r37_retarget", bus.imem_addr, 32'h0000_0100);
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'hBAD0_BAD0, 0, 0, 0); step();
      chk("r37_stale_dropped", bus.inst_valid, 0);
      chk("r37_idle", bus.imem_req, 0);
      drive(0, 0, 0, 0, 0, 0); step();
      chk("r37_req_new", bus.imem_req, 1);
      chk("r37_addr_new", bus.imem_addr, 32'h0000_0100);
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h00A0_0093, 0, 0, 0); step();
      chk("r37_valid", bus.inst_valid, 1);
      chk("r37_pc", bus.inst_pc, 32'h0000_0100);
      chk("r37_inst", bus.inst, 32'h00A0_0093);
      drive(0, 0, 0, 0, 0, 0);

      // ---- redirect + cpu_ready + rvalid together with one word buffered ----
      do_reset();
      step();
      chk("r40_req0", bus.imem_req, 1);
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h1111_0001, 0, 0, 0); step();
      chk("r40_buf", bus.inst_valid, 1);
      drive(0, 0, 0, 0, 0, 0); step();
      chk("r40_req1", bus.imem_req, 1);
      chk("r40_addr1", bus.imem_addr, 32'h4);
      drive(1, 0, 0, 0, 0, 0); step();
      chk("r40_head", bus.inst_pc, 32'h0);
      drive(0, 1, 32'h57A1_E000, 1, 1, 32'h0000_0401); step();
      chk("r40_flush", bus.inst_valid, 0);
      chk("r40_no_req", bus.imem_req, 0);
      chk("r40_addr", bus.imem_addr, 32'h0000_0400);
      drive(0, 0, 0, 0, 0, 0); step();
      chk("r40_req_new", bus.imem_req, 1);
      chk("r40_addr_new", bus.imem_addr, 32'h0000_0400);
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h2222_0002, 0, 0, 0); step();
      chk("r40_valid", bus.inst_valid, 1);
      chk("r40_pc", bus.inst_pc, 32'h0000_0400);
      chk("r40_inst", bus.inst, 32'h2222_0002);
      drive(0, 0, 0, 0, 0, 0);

      // ---- reset asserted mid-WAIT, then a late response ----
      do_reset();
      step();
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h3333_0003, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 0); step();
      chk("r39_pre_inst", bus.inst, 32'h3333_0003);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("r39_rst_req", bus.imem_req, 0);
      chk("r39_rst_addr", bus.imem_addr, 32'h0);
      chk("r39_rst_valid", bus.inst_valid, 0);
      chk("r39_rst_inst", bus.inst, 32'h0);
      chk("r39_rst_pc", bus.inst_pc, 32'h0);
      step(); step();
      rst = 1'b1;
      drive(0, 1, 32'hDEAD_0BAD, 0, 0, 0); step();
      chk("r39_late_ignored", bus.inst_valid, 0);
      chk("r39_req", bus.imem_req, 1);
      chk("r39_addr", bus.imem_addr, 32'h0);
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h4444_0004, 0, 0, 0); step();
      chk("r39_pc", bus.inst_pc, 32'h0);
      chk("r39_inst", bus.inst, 32'h4444_0004);
      drive(0, 0, 0, 0, 0, 0);

      // ---- randomized traffic against a stream-level model ----
      do_reset();
      pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
      exp_pc = 32'h0; prev_redir = 1'b0; n_consumed = 0;
      for (int c = 0; c < 4000; c++) begin
         if (prev_redir) chk("rnd_flush", bus.inst_valid, 0);
         if (bus.inst_valid) begin
            chk("rnd_pc", bus.inst_pc, exp_pc);
            chk("rnd_inst", bus.inst, mem_word(exp_pc));
         end
         had_pend = pend;
         r_rv = 1'b0;
         r_rd = $urandom;
         if (pend) begin
            if (pend_cnt == 0) begin
               r_rv = 1'b1;
               r_rd = mem_word(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end else if ($urandom_range(15, 0) == 0) begin
            r_rv = 1'b1;
            r_rd = 32'hDEAD_BEEF;
         end
         r_g = ($urandom_range(2, 0) != 0);
         if (bus.imem_req && r_g) begin
            chk("rnd_single_outstanding", had_pend, 0);
            pend = 1'b1;
            pend_addr = bus.imem_addr;
            pend_cnt = $urandom_range(2, 0);
         end
         r_rdy = ($urandom_range(3, 0) != 0);
         r_rdr = ($urandom_range(23, 0) == 0);
         r_rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         if (r_rdr) begin
            exp_pc = r_rpc & ~32'h3;
         end else if (bus.inst_valid && r_rdy) begin
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
         end
         prev_redir = r_rdr;
         drive(r_g, r_rv, r_rd, r_rdy, r_rdr, r_rpc);
         step();
      end
      chk("rnd_progress", (n_consumed >= 100) ? 32'd1 : 32'd0, 32'd1);
      drive(0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
